// File: rtl/fft_in_framer.sv
// Audio-to-FFT framer: buffers samples in a FIFO and emits gap-free frames of
// FRAME_LEN points on an Avalon-ST source with SOP/EOP once a frame is buffered.
module fft_in_framer #(
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              audio_valid,
  input  logic [DATA_W-1:0] audio_data,
  output logic              fft_valid,
  input  logic              fft_ready,
  output logic              fft_sop,
  output logic              fft_eop,
  output logic [DATA_W-1:0] fft_real,
  output logic [DATA_W-1:0] fft_imag,
  output logic [1:0]        fft_error,
  output logic [9:0]        fft_fftpts,
  output logic              fft_inverse,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(FRAME_LEN);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_addr;
  logic [CW-1:0]     count_reg;
  logic [IW-1:0]     index_reg;
  logic              valid_reg, overflow_reg;
  logic [DATA_W-1:0] real_reg;
  logic              full, wr_en, drop, handshake, last_beat, load_en;

  assign full      = (count_reg == CW'(FIFO_DEPTH));
  assign wr_en     = audio_valid && !full;
  assign drop      = audio_valid && full;
  assign handshake = valid_reg && fft_ready;
  assign last_beat = (index_reg == IW'(FRAME_LEN - 1));

  // load_en fetches the next head into the output register; in STREAM the
  // head after the one being popped is already buffered, so no stall is needed.
  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    rd_addr    = rd_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (count_reg >= CW'(FRAME_LEN)) begin
          state_next = STREAM;
          load_en    = 1'b1;
        end
      end
      STREAM: begin
        rd_addr = rd_ptr_reg + 1'b1;
        if (handshake) begin
          if (last_beat) state_next = IDLE;
          else           load_en    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= audio_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      index_reg    <= '0;
      valid_reg    <= 1'b0;
      real_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= (state_next == STREAM);
      if (wr_en)     wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (handshake) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, handshake})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (state_reg == IDLE) index_reg <= '0;
      else if (handshake)    index_reg <= index_reg + 1'b1;
      if (load_en) real_reg <= mem[rd_addr];
      if (drop)              overflow_reg <= 1'b1;
      else if (overflow_clr) overflow_reg <= 1'b0;
    end
  end

  assign fft_valid   = valid_reg;
  assign fft_sop     = valid_reg && (index_reg == '0);
  assign fft_eop     = valid_reg && last_beat;
  assign fft_real    = real_reg;
  assign fft_imag    = '0;
  assign fft_error   = 2'b00;
  assign fft_fftpts  = 10'(FRAME_LEN);
  assign fft_inverse = 1'b0;
  assign overflow    = overflow_reg;

endmodule
